// File: rtl/ysyx_22040237_mdu.sv
// Iterative RV64M multiply/divide unit: radix-2 shift-add multiply,
// restoring divide, with 1-cycle shortcuts for div-by-zero, signed
// overflow and reserved opcodes.
`ifndef REG_WIDTH
`define REG_WIDTH 64
`endif

module ysyx_22040237_mdu (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [3:0]              mdu_op_i,
  input  logic [`REG_WIDTH-1:0]   src1_i,
  input  logic [`REG_WIDTH-1:0]   src2_i,
  input  logic [4:0]              rd_idx_i,
  input  logic                    rd_wr_en_i,
  input  logic                    flush_i,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    rd_wr_en_o,
  output logic [4:0]              rd_idx_o,
  output logic [`REG_WIDTH-1:0]   rd_data_o
);

  localparam int unsigned XLEN = `REG_WIDTH;

  localparam logic [3:0] OP_MUL    = 4'd0;
  localparam logic [3:0] OP_MULH   = 4'd1;
  localparam logic [3:0] OP_MULHSU = 4'd2;
  localparam logic [3:0] OP_MULHU  = 4'd3;
  localparam logic [3:0] OP_DIV    = 4'd4;
  localparam logic [3:0] OP_DIVU   = 4'd5;
  localparam logic [3:0] OP_REM    = 4'd6;
  localparam logic [3:0] OP_REMU   = 4'd7;
  localparam logic [3:0] OP_MULW   = 4'd8;
  localparam logic [3:0] OP_DIVW   = 4'd9;
  localparam logic [3:0] OP_DIVUW  = 4'd10;
  localparam logic [3:0] OP_REMW   = 4'd11;
  localparam logic [3:0] OP_REMUW  = 4'd12;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] x);
    return {{(XLEN-32){x[31]}}, x};
  endfunction

  logic [1:0]        state, state_n;
  logic [6:0]        cnt, cnt_n;
  logic [2*XLEN-1:0] acc, acc_n;
  logic [XLEN-1:0]   opb, opb_n;
  logic [3:0]        op_q, op_n;
  logic              w_q, w_n, mul_q, mul_n, neg1_q, neg1_n, neg2_q, neg2_n;
  logic [4:0]        tag_idx, tag_idx_n;
  logic              tag_wen, tag_wen_n;
  logic [XLEN-1:0]   res_n;
  logic              in_ready_n, out_valid_n, rd_wr_en_n;
  logic [4:0]        rd_idx_n;
  logic [XLEN-1:0]   rd_data_n;

  // Request decode, operand magnitudes and shortcut detection
  logic            in_w, in_mul, in_rsv, in_rem, s1_signed, s2_signed, sdiv;
  logic            neg1, neg2, div_zero, div_ovf;
  logic [XLEN-1:0] mag1, mag2, dividend, special_res;

  always_comb begin
    in_rsv    = (mdu_op_i > OP_REMUW);
    in_w      = mdu_op_i inside {OP_MULW, OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW};
    in_mul    = mdu_op_i inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_MULW};
    in_rem    = mdu_op_i inside {OP_REM, OP_REMU, OP_REMW, OP_REMUW};
    sdiv      = mdu_op_i inside {OP_DIV, OP_REM, OP_DIVW, OP_REMW};
    s1_signed = sdiv | (mdu_op_i == OP_MULH) | (mdu_op_i == OP_MULHSU);
    s2_signed = sdiv | (mdu_op_i == OP_MULH);
    neg1      = s1_signed & (in_w ? src1_i[31] : src1_i[XLEN-1]);
    neg2      = s2_signed & (in_w ? src2_i[31] : src2_i[XLEN-1]);
    if (in_w) begin
      mag1 = {32'd0, neg1 ? (32'd0 - src1_i[31:0]) : src1_i[31:0]};
      mag2 = {32'd0, neg2 ? (32'd0 - src2_i[31:0]) : src2_i[31:0]};
    end else begin
      mag1 = neg1 ? (XLEN'(0) - src1_i) : src1_i;
      mag2 = neg2 ? (XLEN'(0) - src2_i) : src2_i;
    end
    dividend = in_w ? sext32(src1_i[31:0]) : src1_i;
    div_zero = !in_mul && !in_rsv &&
               (in_w ? (src2_i[31:0] == 32'd0) : (src2_i == XLEN'(0)));
    div_ovf  = sdiv &&
               (in_w ? (src1_i[31:0] == 32'h8000_0000 && src2_i[31:0] == 32'hFFFF_FFFF)
                     : (src1_i == {1'b1, (XLEN-1)'(0)} && src2_i == {XLEN{1'b1}}));
    if (in_rsv)        special_res = '0;
    else if (div_zero) special_res = in_rem ? dividend : {XLEN{1'b1}};
    else               special_res = in_rem ? '0 : dividend;
  end

  // One iteration of shift-add multiply or restoring divide
  logic [XLEN:0]     mul_sum, rem_sh, diff;
  logic              qbit;
  logic [2*XLEN-1:0] acc_step;

  always_comb begin
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb} : (XLEN+1)'(0));
    rem_sh   = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    diff     = rem_sh - {1'b0, opb};
    qbit     = ~diff[XLEN];
    if (mul_q) acc_step = {mul_sum, acc[XLEN-1:1]};
    else       acc_step = {qbit ? diff[XLEN-1:0] : rem_sh[XLEN-1:0], acc[XLEN-2:0], qbit};
  end

  // Sign correction and result selection applied on the last iteration
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   quo_s, rem_s, calc_res;

  always_comb begin
    prod   = w_q ? {32'd0, acc_step[2*XLEN-1:32]} : acc_step;
    prod_s = (neg1_q ^ neg2_q) ? ((2*XLEN)'(0) - prod) : prod;
    quo_s  = (neg1_q ^ neg2_q) ? (XLEN'(0) - acc_step[XLEN-1:0]) : acc_step[XLEN-1:0];
    rem_s  = neg1_q ? (XLEN'(0) - acc_step[2*XLEN-1:XLEN]) : acc_step[2*XLEN-1:XLEN];
    case (op_q)
      OP_MUL:                        calc_res = prod_s[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  calc_res = prod_s[2*XLEN-1:XLEN];
      OP_MULW:                       calc_res = sext32(prod_s[31:0]);
      OP_DIV, OP_DIVU:               calc_res = quo_s;
      OP_REM, OP_REMU:               calc_res = rem_s;
      OP_DIVW, OP_DIVUW:             calc_res = sext32(quo_s[31:0]);
      OP_REMW, OP_REMUW:             calc_res = sext32(rem_s[31:0]);
      default:                       calc_res = '0;
    endcase
  end

  // Next-state, datapath and registered-output logic
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    acc_n     = acc;
    opb_n     = opb;
    op_n      = op_q;
    w_n       = w_q;
    mul_n     = mul_q;
    neg1_n    = neg1_q;
    neg2_n    = neg2_q;
    tag_idx_n = tag_idx;
    tag_wen_n = tag_wen;
    res_n     = rd_data_o;
    case (state)
      IDLE: begin
        if (in_valid && !flush_i) begin
          op_n      = mdu_op_i;
          w_n       = in_w;
          mul_n     = in_mul;
          neg1_n    = neg1;
          neg2_n    = neg2;
          opb_n     = mag2;
          tag_idx_n = rd_idx_i;
          tag_wen_n = rd_wr_en_i;
          acc_n     = (!in_mul && in_w) ? {XLEN'(0), mag1[31:0], 32'd0} : {XLEN'(0), mag1};
          if (in_rsv || div_zero || div_ovf) begin
            state_n = DONE;
            cnt_n   = 7'd0;
            res_n   = special_res;
          end else begin
            state_n = CALC;
            cnt_n   = in_w ? 7'd32 : 7'd64;
          end
        end
      end
      CALC: begin
        acc_n = acc_step;
        cnt_n = cnt - 7'd1;
        if (cnt == 7'd1) begin
          state_n = DONE;
          res_n   = calc_res;
        end
      end
      DONE: begin
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (flush_i) state_n = IDLE;
    in_ready_n  = (state_n == IDLE);
    out_valid_n = (state_n == DONE);
    rd_wr_en_n  = out_valid_n ? tag_wen_n : 1'b0;
    rd_idx_n    = out_valid_n ? tag_idx_n : 5'd0;
    rd_data_n   = out_valid_n ? res_n : '0;
  end

  // State, datapath and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      acc        <= '0;
      opb        <= '0;
      op_q       <= '0;
      w_q        <= 1'b0;
      mul_q      <= 1'b0;
      neg1_q     <= 1'b0;
      neg2_q     <= 1'b0;
      tag_idx    <= '0;
      tag_wen    <= 1'b0;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      rd_wr_en_o <= 1'b0;
      rd_idx_o   <= '0;
      rd_data_o  <= '0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      acc        <= acc_n;
      opb        <= opb_n;
      op_q       <= op_n;
      w_q        <= w_n;
      mul_q      <= mul_n;
      neg1_q     <= neg1_n;
      neg2_q     <= neg2_n;
      tag_idx    <= tag_idx_n;
      tag_wen    <= tag_wen_n;
      in_ready   <= in_ready_n;
      out_valid  <= out_valid_n;
      rd_wr_en_o <= rd_wr_en_n;
      rd_idx_o   <= rd_idx_n;
      rd_data_o  <= rd_data_n;
    end
  end

endmodule

// File: tb/tb_ysyx_22040237_mdu.sv
// Self-checking bench for ysyx_22040237_mdu: vector table through a
// scoreboard, plus stall, flush and reset sequences.
`timescale 1ns/1ps
module tb_ysyx_22040237_mdu;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  mdu_op_i = 4'd0;
  logic [63:0] src1_i = 64'd0;
  logic [63:0] src2_i = 64'd0;
  logic [4:0]  rd_idx_i = 5'd0;
  logic        rd_wr_en_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        rd_wr_en_o;
  logic [4:0]  rd_idx_o;
  logic [63:0] rd_data_o;

  always #5 clk = ~clk;

  ysyx_22040237_mdu dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .mdu_op_i(mdu_op_i), .src1_i(src1_i), .src2_i(src2_i),
    .rd_idx_i(rd_idx_i), .rd_wr_en_i(rd_wr_en_i), .flush_i(flush_i),
    .out_valid(out_valid), .out_ready(out_ready), .rd_wr_en_o(rd_wr_en_o),
    .rd_idx_o(rd_idx_o), .rd_data_o(rd_data_o)
  );

  typedef struct {
    logic [3:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [4:0]  idx;
    logic        wen;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  typedef struct {
    logic [63:0] data;
    logic [4:0]  idx;
    logic        wen;
    int          lat;
  } exp_t;

  localparam int NVEC = 23;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  vec_t tbl [NVEC];
  exp_t sb [$];
  int   total = 0;
  int   bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                       input logic [4:0] idx, input logic wen);
    mdu_op_i = op; src1_i = a; src2_i = b; rd_idx_i = idx; rd_wr_en_i = wen;
    in_valid = 1'b1;
  endtask

  task automatic scramble();
    mdu_op_i = 4'($urandom_range(0, 15));
    src1_i   = {$urandom(), $urandom()};
    src2_i   = {$urandom(), $urandom()};
    rd_idx_i = 5'($urandom());
  endtask

  // Wait for out_valid, counting cycles from the accept edge; pop and compare.
  task automatic wait_result(input string name);
    int   lat;
    exp_t e;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    if (sb.size() == 0) begin
      total++; bad++;
      $display("FAIL %s scoreboard empty", name);
    end else begin
      e = sb.pop_front();
      chk({name, " latency"}, 64'(lat), 64'(e.lat));
      chk({name, " data"}, rd_data_o, e.data);
      chk({name, " idx"}, 64'(rd_idx_o), 64'(e.idx));
      chk({name, " wen"}, 64'(rd_wr_en_o), 64'(e.wen));
    end
  endtask

  task automatic run_vec(input vec_t v, input string name);
    exp_t e;
    e = '{v.exp, v.idx, v.wen, v.lat};
    sb.push_back(e);
    drive(v.op, v.a, v.b, v.idx, v.wen);
    @(posedge clk); #1;
    in_valid = 1'b0;
    scramble();
    wait_result(name);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({name, " back to idle"}, 64'({in_ready, out_valid, rd_wr_en_o, rd_idx_o}), 64'h80);
    chk({name, " idle data"}, rd_data_o, 64'd0);
  endtask

  task automatic watch_quiet(input string name, input int cycles);
    logic rose;
    rose = 1'b0;
    for (int k = 0; k < cycles; k++) begin
      @(posedge clk); #1;
      if (out_valid) rose = 1'b1;
    end
    chk(name, 64'(rose), 64'd0);
  endtask

  initial begin
    tbl[0]  = '{4'd0,  64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB, 65};
    tbl[1]  = '{4'd3,  ONES, ONES, 5'd1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 65};
    tbl[2]  = '{4'd1,  ONES, ONES, 5'd2, 1'b0, 64'd0, 65};
    tbl[3]  = '{4'd4,  64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd3, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 65};
    tbl[4]  = '{4'd6,  64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd4, 1'b1, ONES, 65};
    tbl[5]  = '{4'd9,  64'h0000_0000_8000_0000, ONES, 5'd6, 1'b1, 64'hFFFF_FFFF_8000_0000, 1};
    tbl[6]  = '{4'd5,  64'd100, 64'd0, 5'd7, 1'b1, ONES, 1};
    tbl[7]  = '{4'd12, 64'h0000_0001_8000_0005, 64'd0, 5'd8, 1'b1, 64'hFFFF_FFFF_8000_0005, 1};
    tbl[8]  = '{4'd8,  64'hABCD_0000_7FFF_FFFF, 64'd2, 5'd9, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 33};
    tbl[9]  = '{4'd2,  ONES, 64'd2, 5'd10, 1'b0, ONES, 65};
    tbl[10] = '{4'd10, 64'h1234_5678_FFFF_FFFF, 64'hFFFF_0000_0000_0002, 5'd11, 1'b1, 64'h0000_0000_7FFF_FFFF, 33};
    tbl[11] = '{4'd11, 64'h0000_0000_FFFF_FFF9, 64'd3, 5'd12, 1'b1, ONES, 33};
    tbl[12] = '{4'd4,  64'h8000_0000_0000_0000, ONES, 5'd13, 1'b1, 64'h8000_0000_0000_0000, 1};
    tbl[13] = '{4'd6,  64'h8000_0000_0000_0000, ONES, 5'd14, 1'b1, 64'd0, 1};
    tbl[14] = '{4'd6,  64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 5'd15, 1'b1, 64'hFFFF_FFFF_FFFF_FFFB, 1};
    tbl[15] = '{4'd13, 64'd123, 64'd4, 5'd16, 1'b1, 64'd0, 1};
    tbl[16] = '{4'd5,  64'd100, 64'd7, 5'd17, 1'b1, 64'd14, 65};
    tbl[17] = '{4'd7,  64'd100, 64'd7, 5'd18, 1'b0, 64'd2, 65};
    tbl[18] = '{4'd0,  64'h1234_5678, 64'h1000, 5'd19, 1'b1, 64'h0000_0123_4567_8000, 65};
    tbl[19] = '{4'd1,  64'h4000_0000_0000_0000, 64'd4, 5'd20, 1'b1, 64'd1, 65};
    tbl[20] = '{4'd9,  64'h0000_0000_FFFF_FFF9, 64'd2, 5'd21, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 33};
    tbl[21] = '{4'd12, 64'd100, 64'd7, 5'd22, 1'b1, 64'd2, 33};
    tbl[22] = '{4'd1,  64'hFFFF_FFFF_FFFF_FFF9, 64'd3, 5'd23, 1'b1, ONES, 65};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset ctrl", 64'({in_ready, out_valid, rd_wr_en_o, rd_idx_o}), 64'h80);
    chk("reset data", rd_data_o, 64'd0);
    rst = 1'b1;

    for (int i = 0; i < NVEC; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Back-pressure: hold DONE for 10 cycles with a competing request present
    sb.push_back('{ONES, 5'd21, 1'b1, 1});
    drive(4'd5, 64'd55, 64'd0, 5'd21, 1'b1);
    @(posedge clk); #1;
    drive(4'd5, 64'd9, 64'd0, 5'd2, 1'b0);
    wait_result("stall");
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      chk($sformatf("stall hold%0d", k),
          64'({in_ready, out_valid, rd_wr_en_o, rd_idx_o}), 64'({1'b0, 1'b1, 1'b1, 5'd21}));
      chk($sformatf("stall data%0d", k), rd_data_o, ONES);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("stall release", 64'({in_ready, out_valid}), 64'b10);
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("no accept on release edge", 64'({in_ready, out_valid}), 64'b10);

    // Flush in CALC cycle 20
    drive(4'd4, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd3, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (19) begin @(posedge clk); #1; end
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    chk("flush idle", 64'({in_ready, out_valid, rd_wr_en_o}), 64'b100);
    watch_quiet("flush no output", 80);

    // Flush blocks a request in IDLE
    drive(4'd5, 64'd1, 64'd0, 5'd4, 1'b1);
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0; in_valid = 1'b0;
    chk("flush blocks accept", 64'({in_ready, out_valid}), 64'b10);

    // Asynchronous reset mid-CALC
    drive(4'd0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd5, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    rst = 1'b0;
    #1;
    chk("async reset ctrl", 64'({in_ready, out_valid, rd_wr_en_o, rd_idx_o}), 64'h80);
    chk("async reset data", rd_data_o, 64'd0);
    repeat (3) @(posedge clk);
    #1;
    sb.push_back('{ONES, 5'd7, 1'b1, 1});
    drive(4'd5, 64'd5, 64'd0, 5'd7, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_result("post-reset accept");
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    watch_quiet("reset no stale output", 80);

    chk("scoreboard drained", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ysyx_22040237_mdu.md
YSYX_22040237_MDU -- requirements
Module: ysyx_22040237_mdu

Interface
REQ-001 The block SHALL have no parameters; the data width SHALL be the codebase REG_WIDTH macro, which is 64.
REQ-002 The port `clk` SHALL be an input, 1 bit wide, and the single clock; all state SHALL update on its rising edge.
REQ-003 The port `rst` SHALL be an input, 1 bit wide, acting as an asynchronous, active-low reset.
REQ-004 The port `in_valid` SHALL be an input, 1 bit wide, indicating that an operation request is valid.
REQ-005 The port `in_ready` SHALL be an output, 1 bit wide, indicating that the unit can accept a request.
REQ-006 The port `mdu_op_i` SHALL be an input, 4 bits wide, with encoding 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU, 8 MULW, 9 DIVW, 10 DIVUW, 11 REMW, 12 REMUW; codes 13-15 are reserved.
REQ-007 The ports `src1_i` and `src2_i` SHALL be inputs, 64 bits each, carrying the rs1 and rs2 operands.
REQ-008 The ports `rd_idx_i` (5 bits) and `rd_wr_en_i` (1 bit) SHALL be inputs carrying destination register tags.
REQ-009 The port `flush_i` SHALL be an input, 1 bit wide, that kills any in-flight operation.
REQ-010 The port `out_valid` SHALL be an output, 1 bit wide, indicating that the result presented is valid.
REQ-011 The port `out_ready` SHALL be an input, 1 bit wide, indicating that the downstream LSU accepts the result.
REQ-012 The outputs `rd_wr_en_o` (1 bit), `rd_idx_o` (5 bits) and `rd_data_o` (64 bits) SHALL drive the LSU's `rd_wr_en_i`, `rd_idx_i` and `alu_res_i` respectively.

Function
REQ-013 The state machine SHALL have exactly three states: IDLE, CALC and DONE.
REQ-014 `in_ready` SHALL be 1 only in IDLE; a request is accepted on a rising edge where `in_valid` and `in_ready` are both 1.
REQ-015 On accept, the block SHALL latch the operation, operand magnitudes, operand signs, `rd_idx_i` and `rd_wr_en_i`.
REQ-016 On accept, the block SHALL enter CALC with an iteration counter of 64 for non-W ops and 32 for W ops.
REQ-017 Multiplication SHALL be radix-2 shift-add, one bit per cycle, into a 128-bit accumulator.
REQ-018 Division SHALL be restoring, one quotient bit per cycle.
REQ-019 For all ops, the counter SHALL decrement once per CALC cycle; when it reaches 0 the block SHALL go to DONE.
REQ-020 Latency: `out_valid` SHALL rise exactly N+1 cycles after the accept edge, where N is 64 or 32.
REQ-021 Signed ops SHALL operate on magnitudes and apply the sign correction when entering DONE.
REQ-022 The quotient sign SHALL be src1 sign XOR src2 sign, and the remainder sign SHALL equal the dividend sign.
REQ-023 MULH, MULHSU and MULHU SHALL return product bits [127:64]; MUL SHALL return product bits [63:0].
REQ-024 W ops SHALL use `src[31:0]`, with the sign taken from bit 31 for signed W ops.
REQ-025 W ops SHALL produce a 32-bit result that is sign-extended to 64 bits, including DIVUW and REMUW.
REQ-026 Divide by zero SHALL skip CALC and go IDLE->DONE, with `out_valid` 1 cycle after accept.
REQ-027 Divide by zero SHALL return all-ones (within width) as the quotient and the dividend (sign-extended for W ops) as the remainder.
REQ-028 Signed overflow (most-negative dividend divided by -1, at 64 or 32 bits) SHALL skip CALC, return quotient = dividend and remainder = 0, with 1-cycle latency.
REQ-029 Reserved codes SHALL skip CALC, produce `rd_data_o` = 0, and have 1-cycle latency.
REQ-030 In DONE, `out_valid` SHALL be 1 and all `rd_*_o` outputs SHALL be held stable until `out_ready` is 1.
REQ-031 A DONE-state edge with `out_ready` = 1 SHALL return the block to IDLE; no new request SHALL be accepted on that same edge.
REQ-032 `rd_wr_en_o` and `rd_idx_o` SHALL equal the latched tags while `out_valid` is 1, and SHALL be 0 otherwise.
REQ-033 `rd_data_o` SHALL be 0 when `out_valid` is 0.
REQ-034 `flush_i` = 1 SHALL force IDLE on the next edge from any state, discarding the operation and any pending result.
REQ-035 If `flush_i` and `in_valid` are both 1 in IDLE, the request SHALL NOT be accepted.
REQ-036 `flush_i` SHALL have priority over `out_ready`.
REQ-037 Operand changes while not in IDLE SHALL have no effect on the in-flight result.

Reset
REQ-038 When `rst` is 0, the block SHALL immediately, and asynchronously, enter IDLE with counter 0, accumulator and latched operands cleared, `out_valid` 0, `in_ready` 1, and `rd_wr_en_o`, `rd_idx_o` and `rd_data_o` all 0.
REQ-039 Reset asserted during CALC or DONE SHALL abandon the operation with no output pulse after release.
REQ-040 After `rst` deasserts, the first accept SHALL be possible on the first rising edge.

Verification
REQ-041 The bench SHALL apply MUL with src1 = 7, src2 = -3 (0xFFFF_FFFF_FFFF_FFFD), `rd_idx_i` = 5, `rd_wr_en_i` = 1, and check that `out_valid` rises 65 cycles later with `rd_data_o` = 0xFFFF_FFFF_FFFF_FFEB, `rd_idx_o` = 5 and `rd_wr_en_o` = 1.
REQ-042 The bench SHALL apply MULHU with both operands 0xFFFF_FFFF_FFFF_FFFF and check that `rd_data_o` = 0xFFFF_FFFF_FFFF_FFFE; it SHALL also apply MULH with -1 × -1 and check that `rd_data_o` = 0.
REQ-043 The bench SHALL apply DIV -7 / 2 and check quotient -3, then REM -7 / 2 and check -1; it SHALL apply DIVW with src1 = 0x0000_0000_8000_0000, src2 = -1 and check `rd_data_o` = 0xFFFF_FFFF_8000_0000 with 1-cycle latency.
REQ-044 The bench SHALL apply DIVU 100 / 0 and check `rd_data_o` = 0xFFFF_FFFF_FFFF_FFFF; it SHALL apply REMUW 0x1_8000_0005 / 0 and check `rd_data_o` = 0xFFFF_FFFF_8000_0005; both SHALL have 1-cycle latency.
REQ-045 The bench SHALL hold `out_ready` = 0 for 10 cycles in DONE and check that the outputs stay stable and `in_ready` = 0 throughout; it SHALL then pulse `out_ready` and check IDLE the next cycle.
REQ-046 The bench SHALL assert `flush_i` in CALC cycle 20 and check that `out_valid` never rises and `in_ready` = 1 next cycle; it SHALL assert `rst` = 0 mid-CALC and check all outputs go 0 immediately.
